// File: rtl/nn_act_pkg.sv
// nn_act_pkg: shared widths, sampler state encoding and index helpers
package nn_act_pkg;
  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;
  localparam int IDX_W  = DATA_W - FRAC_W;
  localparam int DEPTH  = 2 ** IDX_W;
  typedef enum logic [1:0] {IDLE, RD_BASE, RD_NEXT, OUT} state_t;
  function automatic logic [IDX_W-1:0] map_idx(input logic [DATA_W-1:0] v);
    return v[DATA_W-1:FRAC_W] ^ IDX_W'(1 << (IDX_W - 1));
  endfunction
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(DEPTH - 1)) ? i : i + 1'b1;
  endfunction
endpackage

// File: rtl/act_lut_regfile.sv
// act_lut_regfile: activation table with one write port and one registered read port
module act_lut_regfile
  import nn_act_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // write-first read so a lookup issued alongside a write sees the new entry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end
endmodule

// File: rtl/activation_lut_sampler.sv
// activation_lut_sampler: splits x into table index/fraction and fetches base and next samples
module activation_lut_sampler
  import nn_act_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] base,
  output logic [DATA_W-1:0] next__data,
  output logic [DATA_W-1:0] change,
  output logic [DATA_W-1:0] remaining,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack
);
  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              accept;
  assign in_ready = (state == IDLE) || (state == OUT && out_ready);
  assign accept   = in_valid && in_ready;
  assign wr_ack   = wr_en && state == IDLE;
  // base is looked up on the accept edge, the clamped neighbour during RD_BASE
  assign rd_addr  = accept ? map_idx(x) : next_idx(idx);
  act_lut_regfile u_lut (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ack),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
  // sampler FSM with registered operand set
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      base       <= '0;
      next__data <= '0;
      change     <= '0;
      remaining  <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (in_valid) begin
            idx       <= map_idx(x);
            remaining <= DATA_W'(x[FRAC_W-1:0]);
            state     <= RD_BASE;
          end
        RD_BASE: begin
          base  <= rd_data;
          state <= RD_NEXT;
        end
        RD_NEXT: begin
          next__data <= rd_data;
          change     <= rd_data - base;
          out_valid  <= 1'b1;
          state      <= OUT;
        end
        OUT:
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              idx       <= map_idx(x);
              remaining <= DATA_W'(x[FRAC_W-1:0]);
              state     <= RD_BASE;
            end else state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_activation_lut_sampler.sv
// tb_activation_lut_sampler: scoreboard bench with a table-based reference model
module tb_activation_lut_sampler;
  logic       clk = 0, rst = 1, in_valid = 0, out_ready = 0, wr_en = 0;
  logic [7:0] x = 0, wr_data = 0;
  logic [3:0] wr_addr = 0;
  logic       in_ready, out_valid, wr_ack;
  logic [7:0] base, next__data, change, remaining;
  typedef struct {logic [7:0] b, n, c, r;} exp_t;
  exp_t q[$];
  int tbl[16];
  int pass_n = 0, total_n = 0, cyc = 0, last_out = -100, n_out = 0, n_exp = 0;
  bit done = 0;

  activation_lut_sampler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .base(base), .next__data(next__data),
    .change(change), .remaining(remaining), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [7:0] xv);
    exp_t e;
    int v, i, j;
    v = $signed(xv);
    i = (v + 128) / 16;
    j = (i < 15) ? i + 1 : 15;
    e.b = 8'(tbl[i]);
    e.n = 8'(tbl[j]);
    e.c = 8'(tbl[j] - tbl[i]);
    e.r = 8'((v + 128) % 16);
    return e;
  endfunction

  task automatic push(input logic [7:0] xv);
    q.push_back(model(xv));
    n_exp++;
  endtask

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total_n++;
        $display("FAIL spurious_result: got base %0d with no expected entry", $signed(base));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("base", base, e.b);
        chk("next__data", next__data, e.n);
        chk("change", change, e.c);
        chk("remaining", remaining, e.r);
      end
      if (n_out > 0) chk("spacing_ge3", 32'(cyc - last_out >= 3), 1);
      last_out = cyc;
      n_out++;
    end

  task automatic send(input logic [7:0] xv);
    int t = 0;
    x = xv;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total_n++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end else push(xv);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input bit exp_ack);
    wr_en = 1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    chk("wr_ack", wr_ack, exp_ack);
    if (exp_ack) tbl[a] = int'($signed(d));
    @(posedge clk);
    #1 wr_en = 0;
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1;
    while ((q.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (q.size() != 0) begin
      total_n++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] sb, sn, sc, sr;
    int t;
    for (int i = 0; i < 16; i++) tbl[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_base", base, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_remaining", remaining, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) wr(4'(i), 8'((i - 8) * 8), 1);
    out_ready = 1;
    send(8'h35);
    drain();
    send(8'h7F);
    send(8'h80);
    drain();
    out_ready = 0;
    send(8'h35);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("hold_valid", out_valid, 1);
    sb = base; sn = next__data; sc = change; sr = remaining;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_base", base, sb);
      chk("hold_next", next__data, sn);
      chk("hold_change", change, sc);
      chk("hold_remaining", remaining, sr);
    end
    @(posedge clk);
    #1 out_ready = 1;
    x = 8'h80;
    in_valid = 1;
    @(negedge clk);
    chk("same_cycle_accept", in_ready, 1);
    push(8'h80);
    @(posedge clk);
    #1 in_valid = 0;
    drain();
    x = 8'h35;
    in_valid = 1;
    @(negedge clk);
    push(8'h35);
    @(posedge clk);
    #1 in_valid = 0;
    wr(4'd11, 8'd100, 0);
    drain();
    wr(4'd11, 8'd100, 1);
    send(8'h35);
    drain();
    wr_en = 1; wr_addr = 4'd12; wr_data = 8'd50;
    x = 8'h35; in_valid = 1;
    @(negedge clk);
    chk("wr_ack_with_read", wr_ack, 1);
    tbl[12] = 50;
    push(8'h35);
    @(posedge clk);
    #1 in_valid = 0; wr_en = 0;
    drain();
    x = 8'h35; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    #1 rst = 1;
    q.delete();
    for (int i = 0; i < 16; i++) tbl[i] = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_base", base, 0);
    chk("midrst_next", next__data, 0);
    chk("midrst_change", change, 0);
    @(posedge clk);
    #1 rst = 0;
    send(8'h35);
    drain();
    for (int i = 0; i < 16; i++) wr(4'(i), 8'($urandom), 1);
    fork
      begin
        for (int k = 0; k < 10; k++) send(8'($urandom));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    chk("result_count", n_out, n_exp);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
